// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and default sizing for the UART transmit scheduler.
// Holds the FSM state encoding and the default requester count and
// BUSY timeout length used by the scheduler and its interface.
package uart_sched_pkg;

  localparam int DEF_NREQ        = 4;
  localparam int DEF_TIMEOUT_CYC = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2
  } state_t;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Byte-producer and transmitter handshake bundle for the scheduler.
// The slave modport is the scheduler's view; the master modport is the
// view of the producers plus the UART transmitter that surround it.
interface uart_tx_scheduler_if import uart_sched_pkg::*; #(
  parameter int NREQ = DEF_NREQ
);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic              TxStart;
  logic [7:0]        TxData;
  logic              TxDone;

  modport master (
    output req_valid, req_data, TxDone,
    input  req_ack, TxStart, TxData
  );

  modport slave (
    input  req_valid, req_data, TxDone,
    output req_ack, TxStart, TxData
  );

endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Rotate-priority picker: scans requests starting at i_ptr and wrapping
// modulo NREQ, returning the first pending one as one-hot and as an index.
// Purely combinational; the caller registers whatever it needs.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_any
);

  localparam int IDW = $clog2(NREQ);

  // w_pos[k] is the requester examined at scan offset k from the pointer
  logic [IDW-1:0] w_pos [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_pos
      assign w_pos[gi] = ((int'(i_ptr) + gi) >= NREQ) ? IDW'(int'(i_ptr) + gi - NREQ)
                                                     : IDW'(int'(i_ptr) + gi);
    end
  endgenerate

  // Scan from the farthest offset down so the nearest pending request wins
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = |i_req;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (i_req[w_pos[off]]) begin
        o_idx = w_pos[off];
      end
    end
    o_grant[o_idx] = o_any;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmit path between NREQ byte
// producers. IDLE grants one byte, START launches it (TxStart follows one
// cycle later as a registered pulse), BUSY waits for a TxDone rising edge.
// Optional feature macro: UART_TX_SCHED_TIMEOUT_EN aborts a BUSY wait after
// TIMEOUT_CYC cycles and raises a sticky err_timeout flag.
module uart_tx_scheduler import uart_sched_pkg::*; #(
  parameter int NREQ        = DEF_NREQ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  uart_tx_scheduler_if.slave      bus,
  output logic                    o_busy,
  output logic [$clog2(NREQ)-1:0] o_grant_id,
  input  logic                    i_err_clr,
  output logic                    o_err_timeout
);

  localparam int IDW = $clog2(NREQ);

  state_t          r_state, w_state_next;
  logic            r_txdone_d;
  logic [NREQ-1:0] r_req_ack, w_req_ack_next;
  logic            r_tx_start, w_tx_start_next;
  logic [7:0]      r_tx_data, w_tx_data_next;
  logic [IDW-1:0]  r_grant_id, w_grant_id_next;
  logic [IDW-1:0]  r_ptr, w_ptr_next;
  logic            r_busy, w_busy_next;

  logic [NREQ-1:0] w_arb_grant;
  logic [IDW-1:0]  w_arb_idx;
  logic            w_arb_any;
  logic [7:0]      w_sel_data;
  logic            w_done_edge;
  logic            w_timeout;
  logic            w_finish;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  assign w_sel_data  = bus.req_data[{w_arb_idx, 3'b000} +: 8];
  assign w_done_edge = bus.TxDone & ~r_txdone_d;
  assign w_finish    = (r_state == BUSY) && (w_done_edge || w_timeout);

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] r_to_cnt;
  logic             r_err_timeout;

  // A real completion edge in the final cycle beats the timeout
  assign w_timeout = (r_state == BUSY) && !w_done_edge &&
                     (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Count cycles spent in BUSY; held at zero everywhere else so entry starts fresh
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)               r_to_cnt <= '0;
    else if (r_state != BUSY)   r_to_cnt <= '0;
    else                        r_to_cnt <= r_to_cnt + 1'b1;
  end

  // Sticky abort flag; a simultaneous set beats the clear
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)        r_err_timeout <= 1'b0;
    else if (w_timeout)  r_err_timeout <= 1'b1;
    else if (i_err_clr)  r_err_timeout <= 1'b0;
  end

  assign o_err_timeout = r_err_timeout;
`else
  logic w_unused_cfg;

  assign w_timeout     = 1'b0;
  assign o_err_timeout = 1'b0;
  assign w_unused_cfg  = i_err_clr ^ (TIMEOUT_CYC != 0);
`endif

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic: grant in IDLE, one launch cycle, then wait for completion
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_arb_any) w_state_next = START;
      START:   w_state_next = BUSY;
      BUSY:    if (w_finish)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output logic: next values for every registered output
  always_comb begin
    w_req_ack_next  = '0;
    w_tx_start_next = (r_state == START);
    w_tx_data_next  = r_tx_data;
    w_grant_id_next = r_grant_id;
    w_ptr_next      = r_ptr;
    w_busy_next     = (w_state_next != IDLE);
    if (r_state == IDLE && w_arb_any) begin
      w_req_ack_next  = w_arb_grant;
      w_tx_data_next  = w_sel_data;
      w_grant_id_next = w_arb_idx;
    end
    if (w_finish) begin
      w_ptr_next = (r_grant_id == IDW'(NREQ - 1)) ? '0 : r_grant_id + 1'b1;
    end
  end

  // Output, pointer and TxDone edge-detector registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_req_ack  <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_grant_id <= '0;
      r_ptr      <= '0;
      r_busy     <= 1'b0;
      r_txdone_d <= 1'b0;
    end else begin
      r_req_ack  <= w_req_ack_next;
      r_tx_start <= w_tx_start_next;
      r_tx_data  <= w_tx_data_next;
      r_grant_id <= w_grant_id_next;
      r_ptr      <= w_ptr_next;
      r_busy     <= w_busy_next;
      r_txdone_d <= bus.TxDone;
    end
  end

  assign bus.req_ack = r_req_ack;
  assign bus.TxStart = r_tx_start;
  assign bus.TxData  = r_tx_data;
  assign o_busy      = r_busy;
  assign o_grant_id  = r_grant_id;

endmodule
